// File: rtl/llander_pkg.sv
// Purpose: shared constants for the Lunar Lander input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: PS/2 scancodes of the mapped keys, bit positions inside the
// active-low BUTTON byte, the coin FSM state type and the lever slew helper.
package llander_pkg;

  // Scancodes (low 8 bits only; the extended flag is don't-care)
  localparam logic [7:0] SC_RIGHT_A  = 8'h23;
  localparam logic [7:0] SC_RIGHT_B  = 8'h74;
  localparam logic [7:0] SC_LEFT_A   = 8'h1C;
  localparam logic [7:0] SC_LEFT_B   = 8'h6B;
  localparam logic [7:0] SC_START1_A = 8'h05;
  localparam logic [7:0] SC_START1_B = 8'h16;
  localparam logic [7:0] SC_START2   = 8'h06;
  localparam logic [7:0] SC_FIRE_A   = 8'h3A;
  localparam logic [7:0] SC_FIRE_B   = 8'h14;
  localparam logic [7:0] SC_COIN_A   = 8'h04;
  localparam logic [7:0] SC_COIN_B   = 8'h2E;
  localparam logic [7:0] SC_COIN_C   = 8'h36;
  localparam logic [7:0] SC_THRUST_A = 8'h4B;
  localparam logic [7:0] SC_THRUST_B = 8'h11;
  localparam logic [7:0] SC_SHIELD_A = 8'h42;
  localparam logic [7:0] SC_SHIELD_B = 8'h29;

  // Bit positions in the BUTTON byte
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_START1 = 5;
  localparam int BTN_START2 = 4;
  localparam int BTN_FIRE   = 3;
  localparam int BTN_COIN   = 2;
  localparam int BTN_THRUST = 1;
  localparam int BTN_SHIELD = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } coin_st_t;

  // One lever slew step, saturating at 0 and 255. The 9th bit catches
  // both overflow (going up) and borrow (going down).
  function automatic logic [7:0] ramp_next(input logic [7:0] lvl,
                                           input logic       up,
                                           input logic [7:0] step);
    logic [8:0] sum;
    if (up) begin
      sum = {1'b0, lvl} + {1'b0, step};
      return sum[8] ? 8'hFF : sum[7:0];
    end else begin
      sum = {1'b0, lvl} - {1'b0, step};
      return sum[8] ? 8'h00 : sum[7:0];
    end
  endfunction

endpackage

// File: rtl/llander_inputs_coin_stretch.sv
// Purpose: stretch a coin request edge into a fixed COIN_LEN-cycle active-low pulse.
// Latency: coin_l falls 2 cycles after the req rising edge, low for exactly COIN_LEN cycles.
// Backpressure: none; requests during a pulse or before req drops are ignored.
// Ports: clk_25 clock, RESET_L async active-low reset, req active-high
// coin request, coin_l registered active-low coin-mech output.
module coin_stretch #(
  parameter int COIN_LEN = 250000
) (
  input  logic clk_25,
  input  logic RESET_L,
  input  logic req,
  output logic coin_l
);
  import llander_pkg::*;

  localparam int CW = (COIN_LEN > 1) ? $clog2(COIN_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_LEN - 1);

  coin_st_t      st;
  logic [CW-1:0] cnt;
  logic          req_q;

  // req_q resets high so a request already held through reset is not
  // mistaken for a fresh insert; a new pulse needs req to drop first.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      st     <= IDLE;
      cnt    <= '0;
      req_q  <= 1'b1;
      coin_l <= 1'b1;
    end else begin
      req_q  <= req;
      coin_l <= (st != PULSE);
      case (st)
        IDLE: begin
          if (req && !req_q) begin
            st  <= PULSE;
            cnt <= CNT_LOAD;
          end
        end
        PULSE: begin
          if (cnt == '0) st <= WAIT_REL;
          else           cnt <= cnt - 1'b1;
        end
        WAIT_REL: begin
          if (!req) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/llander_inputs.sv
// Purpose: decode PS/2 keys + joystick into Lunar Lander BUTTON byte and thrust lever.
// Latency: key event 2 cycles, joystick 1 cycle, coin 2 cycles after request edge.
// Backpressure: none; one key event accepted per ps2_key[10] toggle.
// Ports: clk_25 clock, RESET_L async active-low reset, ps2_key {toggle,
// pressed, extended, scancode}, joy active-high joystick OR, buttons
// active-low button byte, thrust_lvl lever position (0 idle .. 255 full).
module llander_inputs #(
  parameter int COIN_LEN  = 250000,
  parameter int RAMP_DIV  = 100000,
  parameter int RAMP_STEP = 4
) (
  input  logic        clk_25,
  input  logic        RESET_L,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  output logic [7:0]  buttons,
  output logic [7:0]  thrust_lvl
);
  import llander_pkg::*;

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
  localparam logic [7:0]    STEP_AMT  = 8'(RAMP_STEP);

  logic          tgl_q;
  logic          primed;
  logic          key_evt;
  logic [7:0]    key_sel;
  logic [7:0]    key_q;     // pressed state per function, BTN_* indexed
  logic [7:0]    req;       // merged active-high requests
  logic [7:3]    btn_hi;
  logic [1:0]    btn_lo;
  logic          coin_l;
  logic [PW-1:0] presc;
  logic          step;
  logic          unused_ok;

  assign unused_ok = ^{joy[15:8], joy[3:2], ps2_key[8]};

  // Nothing is decoded until the toggle bit has been sampled once after
  // reset, otherwise a stale event left on the bus would replay.
  assign key_evt = primed && (ps2_key[10] != tgl_q);

  always_comb begin
    key_sel = 8'h00;
    case (ps2_key[7:0])
      SC_RIGHT_A,  SC_RIGHT_B:             key_sel[BTN_RIGHT]  = 1'b1;
      SC_LEFT_A,   SC_LEFT_B:              key_sel[BTN_LEFT]   = 1'b1;
      SC_START1_A, SC_START1_B:            key_sel[BTN_START1] = 1'b1;
      SC_START2:                           key_sel[BTN_START2] = 1'b1;
      SC_FIRE_A,   SC_FIRE_B:              key_sel[BTN_FIRE]   = 1'b1;
      SC_COIN_A,   SC_COIN_B,  SC_COIN_C:  key_sel[BTN_COIN]   = 1'b1;
      SC_THRUST_A, SC_THRUST_B:            key_sel[BTN_THRUST] = 1'b1;
      SC_SHIELD_A, SC_SHIELD_B:            key_sel[BTN_SHIELD] = 1'b1;
      default:                             key_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      tgl_q  <= 1'b0;
      primed <= 1'b0;
      key_q  <= 8'h00;
    end else begin
      tgl_q  <= ps2_key[10];
      primed <= 1'b1;
      if (key_evt)
        key_q <= (key_q & ~key_sel) | (key_sel & {8{ps2_key[9]}});
    end
  end

  always_comb begin
    req              = key_q;
    req[BTN_RIGHT]   = key_q[BTN_RIGHT]  | joy[0];
    req[BTN_LEFT]    = key_q[BTN_LEFT]   | joy[1];
    req[BTN_START1]  = key_q[BTN_START1] | joy[7];
    req[BTN_FIRE]    = key_q[BTN_FIRE]   | joy[4];
    req[BTN_COIN]    = key_q[BTN_COIN]   | joy[7];
    req[BTN_THRUST]  = key_q[BTN_THRUST] | joy[5];
    req[BTN_SHIELD]  = key_q[BTN_SHIELD] | joy[6];
  end

  // Coin bit is already registered inside the stretcher, so it bypasses
  // the output register used by the other seven bits.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      btn_hi <= 5'h1F;
      btn_lo <= 2'h3;
    end else begin
      btn_hi <= ~req[7:3];
      btn_lo <= ~req[1:0];
    end
  end

  assign buttons = {btn_hi, coin_l, btn_lo};

  coin_stretch #(
    .COIN_LEN (COIN_LEN)
  ) u_coin (
    .clk_25  (clk_25),
    .RESET_L (RESET_L),
    .req     (req[BTN_COIN]),
    .coin_l  (coin_l)
  );

  // Free-running prescaler; the lever only moves on its wrap cycle.
  assign step = (presc == PRESC_MAX);

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      presc      <= '0;
      thrust_lvl <= 8'h00;
    end else begin
      presc <= step ? '0 : presc + 1'b1;
      if (step)
        thrust_lvl <= ramp_next(thrust_lvl, req[BTN_THRUST], STEP_AMT);
    end
  end

endmodule

// File: tb/tb_llander_inputs.sv
// Purpose: self-checking bench for llander_inputs (table vectors, hand sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_llander_inputs;
  localparam int COIN_LEN  = 8;
  localparam int RAMP_DIV  = 4;
  localparam int RAMP_STEP = 100;

  logic        clk_25  = 1'b0;
  logic        RESET_L = 1'b0;
  logic [10:0] ps2_key = 11'h000;
  logic [15:0] joy     = 16'h0000;
  logic [7:0]  buttons;
  logic [7:0]  thrust_lvl;

  llander_inputs #(
    .COIN_LEN  (COIN_LEN),
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk_25     (clk_25),
    .RESET_L    (RESET_L),
    .ps2_key    (ps2_key),
    .joy        (joy),
    .buttons    (buttons),
    .thrust_lvl (thrust_lvl)
  );

  always #5 clk_25 = ~clk_25;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Cycle-counted view: cyc = active edges since reset release; keys are a
  // per-function pressed flag; the coin pulse is a window of cycle numbers.
  int       cyc;
  bit [7:0] m_keys;
  bit [7:0] m_req_q;
  bit       m_primed, m_tgl, m_creq_prev, m_busy, m_cvalid;
  int       m_cstart;
  int       m_lvl;

  function automatic int func_of(input logic [7:0] code);
    case (code)
      8'h23, 8'h74:        return 7;
      8'h1C, 8'h6B:        return 6;
      8'h05, 8'h16:        return 5;
      8'h06:               return 4;
      8'h3A, 8'h14:        return 3;
      8'h04, 8'h2E, 8'h36: return 2;
      8'h4B, 8'h11:        return 1;
      8'h42, 8'h29:        return 0;
      default:             return -1;
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0; m_keys = '0; m_req_q = '0; m_primed = 0; m_tgl = 0;
    m_creq_prev = 1; m_busy = 0; m_cvalid = 0; m_cstart = 0; m_lvl = 0;
  endtask

  task automatic model_edge();
    bit [7:0] r;
    int f;
    if (!RESET_L) return;
    r = m_keys;
    if (joy[0]) r[7] = 1;
    if (joy[1]) r[6] = 1;
    if (joy[7]) begin r[5] = 1; r[2] = 1; end
    if (joy[4]) r[3] = 1;
    if (joy[5]) r[1] = 1;
    if (joy[6]) r[0] = 1;
    cyc++;
    if (m_busy) begin
      if (cyc > m_cstart + COIN_LEN && !r[2]) m_busy = 0;
    end else if (r[2] && !m_creq_prev) begin
      m_busy = 1; m_cvalid = 1; m_cstart = cyc;
    end
    m_creq_prev = r[2];
    if (cyc % RAMP_DIV == 0)
      m_lvl = r[1] ? ((m_lvl + RAMP_STEP > 255) ? 255 : m_lvl + RAMP_STEP)
                   : ((m_lvl < RAMP_STEP) ? 0 : m_lvl - RAMP_STEP);
    m_req_q = r;
    if (m_primed && ps2_key[10] != m_tgl) begin
      f = func_of(ps2_key[7:0]);
      if (f >= 0) m_keys[f] = ps2_key[9];
    end
    m_tgl = ps2_key[10];
    m_primed = 1;
  endtask

  function automatic logic [7:0] exp_btn();
    logic [7:0] b;
    b = ~m_req_q;
    b[2] = !(m_cvalid && cyc >= m_cstart + 1 && cyc <= m_cstart + COIN_LEN);
    return b;
  endfunction

  // ---------------- helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: model the coming edge, then sample at next negedge.
  task automatic tick();
    model_edge();
    @(posedge clk_25);
    @(negedge clk_25);
    check8("buttons", buttons, exp_btn());
    check8("thrust_lvl", thrust_lvl, m_lvl[7:0]);
  endtask

  task automatic send_key(input logic [9:0] v);
    ps2_key = {~ps2_key[10], v};
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    #1;
    check8("rst_buttons", buttons, 8'hFF);
    check8("rst_thrust", thrust_lvl, 8'h00);
    @(negedge clk_25);
    model_reset();
    RESET_L = 1'b1;
  endtask

  typedef struct {
    logic [9:0] key;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[17];
  int   low_cnt, first_low;
  int   lvl_up[4];
  int   lvl_dn[4];
  logic [7:0] codes[20];

  initial begin
    tbl[0]  = '{10'h21C, 8'hBF};  // left press
    tbl[1]  = '{10'h16B, 8'hFF};  // release via other left key, ext set
    tbl[2]  = '{10'h223, 8'h7F};
    tbl[3]  = '{10'h074, 8'hFF};
    tbl[4]  = '{10'h205, 8'hDF};
    tbl[5]  = '{10'h016, 8'hFF};
    tbl[6]  = '{10'h206, 8'hEF};
    tbl[7]  = '{10'h006, 8'hFF};
    tbl[8]  = '{10'h23A, 8'hF7};
    tbl[9]  = '{10'h114, 8'hFF};
    tbl[10] = '{10'h24B, 8'hFD};
    tbl[11] = '{10'h011, 8'hFF};
    tbl[12] = '{10'h342, 8'hFE};
    tbl[13] = '{10'h029, 8'hFF};
    tbl[14] = '{10'h21D, 8'hFF};  // unmapped
    tbl[15] = '{10'h374, 8'h7F};
    tbl[16] = '{10'h023, 8'hFF};
    lvl_up = '{100, 200, 255, 255};
    lvl_dn = '{155, 55, 0, 0};
    codes = '{8'h23, 8'h74, 8'h1C, 8'h6B, 8'h05, 8'h16, 8'h06, 8'h3A, 8'h14, 8'h04,
              8'h2E, 8'h36, 8'h4B, 8'h11, 8'h42, 8'h29, 8'h1D, 8'h00, 8'h5A, 8'hF0};

    // 1: reset with a pressed coin key already on the bus -> no decode
    model_reset();
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h04};
    @(negedge clk_25);
    @(negedge clk_25);
    check8("reset_buttons", buttons, 8'hFF);
    check8("reset_thrust", thrust_lvl, 8'h00);
    RESET_L = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!buttons[2]) low_cnt++;
    end
    check_int("prime_no_coin", low_cnt, 0);
    check8("prime_buttons", buttons, 8'hFF);
    check8("prime_thrust", thrust_lvl, 8'h00);

    // 2: key decode table, 2-cycle latency
    for (int i = 0; i < 17; i++) begin
      send_key(tbl[i].key);
      tick();
      tick();
      check8($sformatf("key_tbl[%0d]", i), buttons, tbl[i].exp);
      tick();
    end

    // 3: coin from keyboard
    do_reset();
    tick();
    send_key(10'h22E);
    low_cnt = 0; first_low = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!buttons[2]) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check_int("coin_key_width", low_cnt, COIN_LEN);
    check_int("coin_key_lat", first_low, 3);
    send_key(10'h02E);
    repeat (3) tick();

    // 4a: joy[7] held 3*COIN_LEN cycles
    joy = 16'h0080;
    low_cnt = 0; first_low = -1;
    for (int i = 1; i <= 3 * COIN_LEN; i++) begin
      tick();
      check8("start1_held", {7'b0, buttons[5]}, 8'h00);
      if (!buttons[2]) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check_int("coin_joy_width", low_cnt, COIN_LEN);
    check_int("coin_joy_lat", first_low, 2);
    joy = 16'h0000;
    repeat (2) tick();

    // 4b: re-press during the pulse does not extend or retrigger
    joy = 16'h0080;
    low_cnt = 0;
    for (int i = 1; i <= 3 * COIN_LEN; i++) begin
      if (i == 4) joy = 16'h0000;
      if (i == 5) joy = 16'h0080;
      tick();
      if (!buttons[2]) low_cnt++;
    end
    check_int("coin_repress_width", low_cnt, COIN_LEN);
    joy = 16'h0000;
    repeat (2) tick();

    // 5: thrust ramp with saturation both ways
    do_reset();
    joy = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      repeat (RAMP_DIV) tick();
      check8($sformatf("ramp_up[%0d]", k), thrust_lvl, 8'(lvl_up[k]));
    end
    joy = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      repeat (RAMP_DIV) tick();
      check8($sformatf("ramp_dn[%0d]", k), thrust_lvl, 8'(lvl_dn[k]));
    end

    // 6: reset mid-pulse at lever 200, request held through reset
    do_reset();
    joy = 16'h0020;
    repeat (6) tick();
    joy = 16'h00A0;
    repeat (3) tick();
    check8("pre_rst_thrust", thrust_lvl, 8'd200);
    check8("pre_rst_coin", {7'b0, buttons[2]}, 8'h00);
    do_reset();
    low_cnt = 0;
    repeat (20) begin
      tick();
      if (!buttons[2]) low_cnt++;
    end
    check_int("no_coin_after_rst", low_cnt, 0);
    joy = 16'h0020;
    tick();
    joy = 16'h00A0;
    low_cnt = 0;
    repeat (12) begin
      tick();
      if (!buttons[2]) low_cnt++;
    end
    check_int("coin_after_new_edge", low_cnt, COIN_LEN);
    joy = 16'h0000;

    // 7: unmapped code changes nothing
    do_reset();
    repeat (2) tick();
    send_key(10'h21D);
    repeat (3) tick();
    check8("unmapped_btn", buttons, 8'hFF);
    check8("unmapped_thr", thrust_lvl, 8'h00);
    send_key(10'h11D);
    repeat (3) tick();
    check8("unmapped_rel_btn", buttons, 8'hFF);

    // 8: random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) joy = 16'($urandom);
      if ($urandom_range(0, 2) == 0)
        send_key({1'($urandom), 1'($urandom), codes[$urandom_range(0, 19)]});
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
